// File: rtl/adder_bench_pkg.sv
// Shared constants, beat arithmetic and loader state encoding for the 140-bit adder bench.
package adder_bench_pkg;

    localparam int ADDER_WIDTH_DEF = 140;

    typedef enum logic [0:0] {
        LOAD_A = 1'b0,
        LOAD_B = 1'b1
    } load_state_e;

    function automatic int calc_beats(input int adder_width, input int chunk_width);
        return (adder_width + chunk_width - 1) / chunk_width;
    endfunction

    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/adder_operand_loader_if.sv
// Chunk stream in, operand pair and strobes out; slave is the loader, master the feeder.
interface adder_operand_loader_if
    import adder_bench_pkg::*;
#(
    parameter int ADDER_WIDTH = ADDER_WIDTH_DEF,
    parameter int CHUNK_WIDTH = 20
);
    logic                   in_valid;
    logic                   in_ready;
    logic [CHUNK_WIDTH-1:0] in_data;
    logic                   flush;
    logic [ADDER_WIDTH-1:0] a;
    logic [ADDER_WIDTH-1:0] b;
    logic                   op_valid;
    logic                   sum_valid;

    modport master (
        output in_valid, in_data, flush,
        input  in_ready, a, b, op_valid, sum_valid
    );

    modport slave (
        input  in_valid, in_data, flush,
        output in_ready, a, b, op_valid, sum_valid
    );
endinterface

// File: rtl/adder_operand_loader_chunk_assembler.sv
// Writes successive chunks into a shadow operand, LS chunk first; exposes next-state shadow.
// Final beat keeps only the bits that fit below ADDER_WIDTH; counter wraps after it.
module chunk_assembler
    import adder_bench_pkg::*;
#(
    parameter int ADDER_WIDTH = ADDER_WIDTH_DEF,
    parameter int CHUNK_WIDTH = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en_i,
    input  logic                   clear_i,
    input  logic [CHUNK_WIDTH-1:0] data_i,
    output logic [ADDER_WIDTH-1:0] shadow_nxt_o,
    output logic                   last_o
);
    localparam int BEATS  = calc_beats(ADDER_WIDTH, CHUNK_WIDTH);
    localparam int CNT_W  = cnt_width(BEATS);
    localparam int LAST_W = ADDER_WIDTH - (BEATS - 1) * CHUNK_WIDTH;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDER_WIDTH-1:0] shadow_q, shadow_d;

    assign last_o       = (cnt_q == LAST_BEAT);
    assign shadow_nxt_o = shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (wr_en_i) begin
            if (last_o) begin
                shadow_d[ADDER_WIDTH-1 -: LAST_W] = data_i[LAST_W-1:0];
                cnt_d = '0;
            end else begin
                shadow_d[int'(cnt_q) * CHUNK_WIDTH +: CHUNK_WIDTH] = data_i;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

endmodule

// File: rtl/adder_operand_loader.sv
// Assembles A then B from a chunk stream and updates both adder operands on one edge.
// op_valid one cycle after the final B beat, sum_valid SUM_LATENCY later; in_ready stays high.
module adder_operand_loader
    import adder_bench_pkg::*;
#(
    parameter int ADDER_WIDTH = ADDER_WIDTH_DEF,
    parameter int CHUNK_WIDTH = 20,
    parameter int SUM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_operand_loader_if.slave bus
);
    localparam logic [0:0] ST_LOAD_A = LOAD_A;
    localparam logic [0:0] ST_LOAD_B = LOAD_B;

    logic [0:0]             state_q, state_d;
    logic                   in_ready_q;
    logic [ADDER_WIDTH-1:0] a_q, b_q;
    logic                   op_valid_q;
    logic [SUM_LATENCY-1:0] sum_pipe_q, sum_pipe_d;

    logic                   accept, wr_a, wr_b, pair_done;
    logic                   last_a, last_b;
    logic [ADDER_WIDTH-1:0] nxt_a, nxt_b;

    // Flush wins over a beat presented in the same cycle.
    assign accept    = bus.in_valid && in_ready_q && !bus.flush;
    assign wr_a      = accept && (state_q == ST_LOAD_A);
    assign wr_b      = accept && (state_q == ST_LOAD_B);
    assign pair_done = wr_b && last_b;

    chunk_assembler #(
        .ADDER_WIDTH (ADDER_WIDTH),
        .CHUNK_WIDTH (CHUNK_WIDTH)
    ) u_asm_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en_i      (wr_a),
        .clear_i      (bus.flush),
        .data_i       (bus.in_data),
        .shadow_nxt_o (nxt_a),
        .last_o       (last_a)
    );

    chunk_assembler #(
        .ADDER_WIDTH (ADDER_WIDTH),
        .CHUNK_WIDTH (CHUNK_WIDTH)
    ) u_asm_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en_i      (wr_b),
        .clear_i      (bus.flush),
        .data_i       (bus.in_data),
        .shadow_nxt_o (nxt_b),
        .last_o       (last_b)
    );

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = ST_LOAD_A;
        end else if (wr_a && last_a) begin
            state_d = ST_LOAD_B;
        end else if (pair_done) begin
            state_d = ST_LOAD_A;
        end
    end

    // Shift op_valid in at bit 0; the top bit is the delayed strobe.
    assign sum_pipe_d = SUM_LATENCY'({sum_pipe_q, op_valid_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOAD_A;
            in_ready_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_valid_q <= 1'b0;
            sum_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= 1'b1;
            op_valid_q <= pair_done;
            sum_pipe_q <= sum_pipe_d;
            if (pair_done) begin
                a_q <= nxt_a;
                b_q <= nxt_b;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.op_valid  = op_valid_q;
    assign bus.sum_valid = sum_pipe_q[SUM_LATENCY-1];

endmodule
